// File: rtl/div.sv
// 32-bit restoring divider, signed/unsigned, 33-cycle latency.
// Optional divide-by-zero shortcut: define DIV_ZERO_DETECT_EN.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

`ifdef DIV_ZERO_DETECT_EN
  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [63:0] result_q, result_d;

  logic        sgn1;
  logic        sgn2;
  logic [32:0] partial;
  logic [32:0] diff;

  // State and datapath registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  // Next-state logic: operand capture, one restoring step per cycle, sign fix-up
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    sgn1    = signed_div_i & opdata1_i[31];
    sgn2    = signed_div_i & opdata2_i[31];
    // Partial remainder stays below the divisor, so 33 bits never overflow
    partial = {rem_q, quo_q[31]};
    diff    = partial - {1'b0, dvs_q};

    case (state_q)
      S_FREE: begin
        result_d = '0;
        if (start_i && !annul_i) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = sgn1 ? (~opdata1_i + 32'd1) : opdata1_i;
          dvs_d  = sgn2 ? (~opdata2_i + 32'd1) : opdata2_i;
          negq_d = sgn1 ^ sgn2;
          negr_d = sgn1;
`ifdef DIV_ZERO_DETECT_EN
          if (opdata2_i == 32'd0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
          end
`else
          state_d = S_ON;
`endif
        end
      end
`ifdef DIV_ZERO_DETECT_EN
      S_BYZERO: begin
        result_d = '0;
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          state_d = S_END;
        end
      end
`endif
      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          result_d = '0;
        end else if (cnt_q == 6'd32) begin
          result_d[31:0]  = negq_q ? (~quo_q + 32'd1) : quo_q;
          result_d[63:32] = negr_q ? (~rem_q + 32'd1) : rem_q;
          state_d         = S_END;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = partial[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_FREE;
          result_d = '0;
        end
      end
      default: begin
        state_d  = S_FREE;
        result_d = '0;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == S_END);

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: expected results queued at drive time,
// popped and compared when ready_o rises.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int          n_cmp;
  int          n_bad;
  logic [63:0] sb[$];

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    na = s & a[31];
    nb = s & b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'd0) return 64'd0;
`endif
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction

  task automatic run_div(input string tag, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int          n;
    int          lat;
    logic [63:0] e;
    lat = 33;
`ifdef DIV_ZERO_DETECT_EN
    if (b == 32'd0) lat = 1;
`endif
    @(negedge clk);
    signed_div = s;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    op1        = $urandom;
    op2        = $urandom;
    signed_div = ~s;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    e = sb.pop_front();
    chk({tag, "_res"}, result, e);
    @(posedge clk);
    #1;
    chk({tag, "_hold_rdy"}, 64'(ready), 64'd1);
    chk({tag, "_hold_res"}, result, e);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop_rdy"}, 64'(ready), 64'd0);
    chk({tag, "_drop_res"}, result, 64'd0);
  endtask

  task automatic quiet_window(input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready) hits++;
    end
    chk(tag, 64'(hits), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic [31:0] a, b;
    logic [63:0] e;
    int          n;
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    signed_div = 1'b0;
    op1        = '0;
    op2        = '0;
    start      = 1'b0;
    annul      = 1'b0;
    #7;
    chk("rst_rdy", 64'(ready), 64'd0);
    chk("rst_res", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("free_rdy", 64'(ready), 64'd0);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_div("smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            64'h00000000_80000000);

    @(negedge clk);
    signed_div = 1'b0;
    op1        = 32'd1000;
    op2        = 32'd3;
    start      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    chk("annul_rdy0", 64'(ready), 64'd0);
    quiet_window("annul_quiet");
    run_div("u20_4", 1'b0, 32'd20, 32'd4, 64'h00000000_00000005);

    @(negedge clk);
    op1   = 32'd1000;
    op2   = 32'd3;
    start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rston_rdy", 64'(ready), 64'd0);
    chk("rston_res", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet_window("rston_quiet");
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    @(negedge clk);
    op1   = 32'd77;
    op2   = 32'd5;
    start = 1'b1;
    sb.push_back(64'h00000002_0000000F);
    @(posedge clk);
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    chk("end_res", result, e);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstend_rdy", 64'(ready), 64'd0);
    chk("rstend_res", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

`ifdef DIV_ZERO_DETECT_EN
    run_div("u5_0", 1'b0, 32'd5, 32'd0, 64'd0);
`else
    run_div("u5_0", 1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
`endif
    run_div("s-5_0", 1'b1, 32'hFFFF_FFFB, 32'd0,
            model(1'b1, 32'hFFFF_FFFB, 32'd0));

    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      run_div("rnd", s, a, b, model(s, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
